// File: rtl/cache_stage_pkg.sv
// Shared definitions for the cache memory-access stage.
//   - load/store request encodings seen on i_ldSt_enable
//   - miss-handling FSM state encodings
//   - address, word and line widths
//   - packed layout of the registered stage output toward writeback
package cache_stage_pkg;

    localparam int ADDR_W     = 16;
    localparam int WORD_W     = 16;
    localparam int LINE_WORDS = 8;
    localparam int LINE_W     = 128;
    localparam int OFF_LSB    = 1;    // addr[0] is ignored (16-bit words)
    localparam int IDX_LSB    = 4;    // first index bit above the word offset

    // 2'b11 is not listed; it is decoded as "no access" by the stage.
    typedef enum logic [1:0] {
        LDST_NONE  = 2'b00,
        LDST_LOAD  = 2'b01,
        LDST_STORE = 2'b10
    } ldst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WB   = 2'b01,
        ST_FILL = 2'b10,
        ST_DONE = 2'b11
    } miss_state_e;

    // Everything the stage hands to writeback, latched as one register.
    typedef struct packed {
        logic [WORD_W-1:0] result;
        logic [2:0]        dest_reg;
        logic              we;
        logic [1:0]        bp;
        logic [2:0]        tail_rob;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        ex_vector;
        logic              ticket_we;
    } stage_out_t;

    // Line-aligned memory address: clear the word offset and byte bits.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_if.sv
// Line-granular request/acknowledge port between the data cache and the
// next memory level.
//   mem_req   : request valid, held with address/we/wdata until mem_ack
//   mem_we    : 1 = write back a victim line, 0 = fetch a line
//   mem_addr  : line-aligned address (low four bits always zero)
//   mem_wdata : victim line for a write back
//   mem_ack   : one-cycle completion pulse from memory
//   mem_rdata : fetched line, valid in the mem_ack cycle
// master = cache side, slave = memory side.
interface cache_mem_if;
    import cache_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/cache_stage_miss_fsm.sv
// Miss sequencer for the direct-mapped data cache.
// Decides stall, walks an optional victim write back followed by a line
// fill on the memory port, and tells the array owner when to install the
// fetched line.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_access          a load/store that must touch the cache this cycle
//   i_hit             the indexed line is valid with a matching tag
//   i_victim_dirty    the indexed line holds modified data
//   i_victim_addr     line address of the current occupant of the index
//   i_fill_addr       line address of the requested data
//   i_victim_line     current contents of the indexed line
//   mem               memory port (cache side)
//   o_stall           pipeline must hold its inputs
//   o_fill_we         install mem_rdata into the indexed line this edge
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no miss outstanding; a missing access raises stall now
// WB      | dirty victim being written back, waiting for mem_ack
// FILL    | requested line being fetched, waiting for mem_ack
// DONE    | line installed; access hits this cycle, stall released
module cache_miss_fsm
    import cache_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_access,
    input  logic              i_hit,
    input  logic              i_victim_dirty,
    input  logic [ADDR_W-1:0] i_victim_addr,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [LINE_W-1:0] i_victim_line,
    cache_mem_if.master       mem,
    output logic              o_stall,
    output logic              o_fill_we
);

    miss_state_e       r_state;
    miss_state_e       w_next;
    logic              w_stall;
    logic              w_fill_we;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [LINE_W-1:0] w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request fields come straight from the held pipeline inputs and the
    // untouched victim entry, so they stay stable until mem_ack without
    // extra holding registers. A reset returns the state to IDLE, which
    // drops mem_req in the same instant.
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_fill_we = 1'b0;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_access && !i_hit) begin
                    w_stall = 1'b1;
                    w_next  = i_victim_dirty ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = i_victim_addr;
                w_wdata = i_victim_line;
                if (mem.mem_ack) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_addr  = i_fill_addr;
                if (mem.mem_ack) begin
                    w_fill_we = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = w_wdata;
    assign o_stall       = w_stall;
    assign o_fill_we     = w_fill_we;

endmodule

// File: rtl/cache_stage.sv
// Memory-access pipeline stage behind the TLB lookup.
// Holds a direct-mapped, write-back, write-allocate data cache of LINES
// lines x 8 sixteen-bit words, performs loads/stores on hits, and registers
// the result plus forwarded control toward writeback. Misses are handed to
// cache_miss_fsm, which stalls the pipe while the line is exchanged.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_enable_cache          output register enable from hazard control
//   i_tlblookup_result      physical address / ALU result
//   i_dataReg               store data
//   i_ldSt_enable           00 none, 01 load, 10 store, 11 none
//   i_ex_vector_input       nonzero: excepting instruction, no cache access
//   i_destReg_addr_input, i_we_input, i_bp_input, i_tail_rob_input,
//   i_pc_input, i_ticketWE_input   forwarded control
//   o_cache_result          load data for loads, else i_tlblookup_result
//   o_*_output              registered copies of the forwarded control
//   o_stall_cache           miss outstanding; upstream must hold inputs
//   mem                     line request port to the next memory level
// Address split: tag = addr[15:4+log2(LINES)], index = addr[3+log2(LINES):4],
// word offset = addr[3:1].
module cache_stage
    import cache_stage_pkg::*;
#(
    parameter int LINES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable_cache,
    input  logic [ADDR_W-1:0] i_tlblookup_result,
    input  logic [WORD_W-1:0] i_dataReg,
    input  logic [1:0]        i_ldSt_enable,
    input  logic [2:0]        i_destReg_addr_input,
    input  logic              i_we_input,
    input  logic [1:0]        i_bp_input,
    input  logic [2:0]        i_tail_rob_input,
    input  logic [ADDR_W-1:0] i_pc_input,
    input  logic [1:0]        i_ex_vector_input,
    input  logic              i_ticketWE_input,
    output logic [WORD_W-1:0] o_cache_result,
    output logic [2:0]        o_destReg_addr_output,
    output logic              o_we_output,
    output logic [1:0]        o_bp_output,
    output logic [2:0]        o_tail_rob_output,
    output logic [ADDR_W-1:0] o_pc_output,
    output logic [1:0]        o_ex_vector_output,
    output logic              o_ticketWE_output,
    output logic              o_stall_cache,
    cache_mem_if.master       mem
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;

    // Cache arrays. Only valid/dirty are reset; tags and data are
    // meaningless until their valid bit is set.
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    stage_out_t        r_out;
    stage_out_t        w_out_next;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [2:0]        w_off;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_access;
    logic              w_hit;
    logic              w_victim_dirty;
    logic [LINE_W-1:0] w_line;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] w_victim_addr;
    logic [ADDR_W-1:0] w_fill_addr;
    logic              w_stall;
    logic              w_fill_we;
    logic              w_store_commit;

    assign w_idx = i_tlblookup_result[IDX_LSB +: IDX_W];
    assign w_tag = i_tlblookup_result[ADDR_W-1 -: TAG_W];
    assign w_off = i_tlblookup_result[OFF_LSB +: 3];

    assign w_is_load  = (i_ldSt_enable == LDST_LOAD);
    assign w_is_store = (i_ldSt_enable == LDST_STORE);
    // Excepting instructions never touch the cache, so they can never stall.
    assign w_access   = (w_is_load || w_is_store) && (i_ex_vector_input == 2'b00);

    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_line         = r_data[w_idx];
    assign w_word         = w_line[{w_off, 4'b0000} +: WORD_W];
    assign w_victim_addr  = {r_tag[w_idx], w_idx, 4'b0000};
    assign w_fill_addr    = line_base(i_tlblookup_result);

    // A store commits only on the edge where the output register also
    // advances; with enable low the whole access simply retries.
    assign w_store_commit = i_enable_cache && w_access && w_is_store && w_hit && !w_stall;

    cache_miss_fsm u_miss_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_access       (w_access),
        .i_hit          (w_hit),
        .i_victim_dirty (w_victim_dirty),
        .i_victim_addr  (w_victim_addr),
        .i_fill_addr    (w_fill_addr),
        .i_victim_line  (w_line),
        .mem            (mem),
        .o_stall        (w_stall),
        .o_fill_we      (w_fill_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill_we) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_store_commit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem.mem_rdata;
        end else if (w_store_commit) begin
            r_data[w_idx][{w_off, 4'b0000} +: WORD_W] <= i_dataReg;
        end
    end

    // While stalled the register takes an all-zero bubble so no write
    // enable reaches writeback before the access really completes.
    always_comb begin
        w_out_next = '0;
        if (!w_stall) begin
            w_out_next.result    = (w_access && w_is_load) ? w_word : i_tlblookup_result;
            w_out_next.dest_reg  = i_destReg_addr_input;
            w_out_next.we        = i_we_input;
            w_out_next.bp        = i_bp_input;
            w_out_next.tail_rob  = i_tail_rob_input;
            w_out_next.pc        = i_pc_input;
            w_out_next.ex_vector = i_ex_vector_input;
            w_out_next.ticket_we = i_ticketWE_input;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (i_enable_cache) begin
            r_out <= w_out_next;
        end
    end

    assign o_cache_result        = r_out.result;
    assign o_destReg_addr_output = r_out.dest_reg;
    assign o_we_output           = r_out.we;
    assign o_bp_output           = r_out.bp;
    assign o_tail_rob_output     = r_out.tail_rob;
    assign o_pc_output           = r_out.pc;
    assign o_ex_vector_output    = r_out.ex_vector;
    assign o_ticketWE_output     = r_out.ticket_we;
    assign o_stall_cache         = w_stall;

endmodule
